// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one 4-bit ALU between NREQ instruction sources.
// A winner is picked from req_valid in IDLE and its 13-bit frame
// {A[3:0], B[3:0], carry, opcode[3:0]} is latched. The ALU is then strobed
// for one cycle, the arbiter waits ALU_LAT cycles, and the result goes back
// to the winner as a one-cycle rsp_valid pulse.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   req_valid[NREQ]     per-requester request
//   req_frame[13*NREQ]  requester i at bits [13*i+12 : 13*i]
//   req_ready[NREQ]     one-hot accept, only in IDLE
//   a_in, b_in, c_in, op_code  latched operands to the ALU
//   alu_en              one-cycle execute strobe
//   alu_result, alu_cout  ALU outputs
//   rsp_valid[NREQ]     one-hot one-cycle response pulse
//   rsp_data            {alu_cout, alu_result} of the last operation
//
// Build option: ALU_ARB_FIXED_PRIO_EN selects fixed priority (lowest index
// wins, no round-robin pointer). Default is round-robin.
module alu_arbiter #(
  parameter int NREQ    = 4,
  parameter int ALU_LAT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [13*NREQ-1:0]   req_frame,
  output logic [NREQ-1:0]      req_ready,
  output logic [3:0]           a_in,
  output logic [3:0]           b_in,
  output logic                 c_in,
  output logic [3:0]           op_code,
  output logic                 alu_en,
  input  logic [3:0]           alu_result,
  input  logic                 alu_cout,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [4:0]           rsp_data
);

  localparam int IW = (NREQ > 2) ? $clog2(NREQ) : 1;
  localparam int unsigned NREQ_U = NREQ;
  localparam logic [2:0] LAT_LAST = 3'(ALU_LAT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [2:0]    cnt_q,   cnt_d;
  logic [12:0]   frame_q, frame_d;
  logic [4:0]    rsp_q,   rsp_d;

  logic          win_vld;
  logic [IW-1:0] win_idx;

`ifndef ALU_ARB_FIXED_PRIO_EN
  logic [IW-1:0] ptr_q, ptr_d;
`endif

  // Winner selection
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
`ifdef ALU_ARB_FIXED_PRIO_EN
    for (int unsigned k = 0; k < NREQ_U; k++) begin
      if (!win_vld && req_valid[IW'(k)]) begin
        win_vld = 1'b1;
        win_idx = IW'(k);
      end
    end
`else
    // Scan upward from the pointer with wrap; first valid index wins.
    for (int unsigned k = 0; k < NREQ_U; k++) begin
      int unsigned idx;
      idx = int'(ptr_q) + k;
      if (idx >= NREQ_U) idx = idx - NREQ_U;
      if (!win_vld && req_valid[IW'(idx)]) begin
        win_vld = 1'b1;
        win_idx = IW'(idx);
      end
    end
`endif
  end

  // Accept is masked during reset so every output sits at its reset value.
  always_comb begin
    req_ready = '0;
    if (state_q == S_IDLE && win_vld && !reset) req_ready[win_idx] = 1'b1;
  end

  always_comb begin
    rsp_valid = '0;
    if (state_q == S_RESP) rsp_valid[grant_q] = 1'b1;
  end

  assign alu_en   = (state_q == S_EXEC);
  assign a_in     = frame_q[12:9];
  assign b_in     = frame_q[8:5];
  assign c_in     = frame_q[4];
  assign op_code  = frame_q[3:0];
  assign rsp_data = rsp_q;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    rsp_d   = rsp_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          frame_d = req_frame[13*win_idx +: 13];
          grant_d = win_idx;
`ifndef ALU_ARB_FIXED_PRIO_EN
          ptr_d   = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
`endif
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == LAT_LAST) begin
          rsp_d   = {alu_cout, alu_result};
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      cnt_q   <= '0;
      frame_q <= '0;
      rsp_q   <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      rsp_q   <= rsp_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter sharing the single 4-bit ALU of the CPU datapath between several instruction sources (control unit, debug port, test injector, etc.). Each requester presents a 13-bit data frame ({A[3:0], B[3:0], carry, opcode[3:0]}) with a valid/ready handshake. The arbiter latches the winning frame, drives the ALU operand/enable lines for one cycle, waits out the ALU latency, and returns the result to the granted requester with a one-cycle response pulse.

## Interface
- NREQ, 4, number of requesters (legal 2..8)
- ALU_LAT, 1, cycles from the alu_en sample edge to the ALU result being valid (legal 1..7)

- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high
- req_valid  input  NREQ  per-requester request
- req_frame  input  13*NREQ  flattened frames; requester i occupies bits [13*i+12 : 13*i]
- req_ready  output  NREQ  one-hot grant/accept; at most one bit high
- a_in, b_in  output  4  latched operands to ALU
- c_in  output  1  latched carry to ALU
- op_code  output  4  latched opcode to ALU
- alu_en  output  1  ALU execute strobe, one cycle per operation
- alu_result  input  4  ALU result
- alu_cout  input  1  ALU carry-out
- rsp_valid  output  NREQ  one-hot, one-cycle response pulse
- rsp_data  output  5  {alu_cout, alu_result} captured for the last operation

## Operation
- States: IDLE, EXEC, WAIT, RESP.
- IDLE: winner is chosen combinationally from req_valid. req_ready[winner] = 1 in the same cycle. Handshake = req_valid[i] & req_ready[i]. On the handshake edge:
  - frame fields load into a_in/b_in/c_in/op_code;
  - the grant index is stored;
  - round-robin pointer becomes (winner+1) mod NREQ;
  - next state is EXEC.
  - No valid request: remain in IDLE, req_ready = 0.
- Round-robin arbitration: search starts at the pointer, ascending with wrap-around. The first valid index wins.
- EXEC: alu_en = 1 for exactly one cycle, with the operands stable. Next state is WAIT and the latency counter is cleared.
- WAIT: lasts ALU_LAT cycles. At the end of the final WAIT cycle, {alu_cout, alu_result} is captured into rsp_data. Next state is RESP.
- RESP: rsp_valid[grant] = 1 for one cycle. Next state is IDLE.
- req_ready is 0 in every state except IDLE. A requester may raise or drop req_valid at any time when not granted, with no effect.
- a_in/b_in/c_in/op_code and rsp_data hold their values after an operation until the next handshake or capture.
- Encoded state values outside the four states go to IDLE with all strobes low.

## Timing
- Reset values:
  - state IDLE, pointer 0;
  - req_ready 0, alu_en 0, rsp_valid 0;
  - a_in, b_in, op_code 0; c_in 0; rsp_data 0.
- Handshake edge at end of cycle 0:
  - cycle 1: EXEC, alu_en high;
  - cycles 2 .. 1+ALU_LAT: WAIT;
  - cycle 2+ALU_LAT: RESP, rsp_valid high;
  - earliest next req_ready in cycle 3+ALU_LAT.
- Throughput: one operation per 3+ALU_LAT cycles. With ALU_LAT=1, that is 4 cycles.
- Reset asserted mid-operation (EXEC, WAIT or RESP):
  - operation aborted, no rsp_valid issued;
  - all outputs go to reset values immediately (asynchronous);
  - the aborted requester must re-request.
- Simultaneous requests: exactly one grant per IDLE cycle. The others keep waiting and see req_ready = 0.
- Wrap-around: pointer NREQ-1 with a grant to NREQ-1 sets the pointer to 0.

## Configuration
- ALU_ARB_FIXED_PRIO_EN
  - Defined: fixed priority. The lowest-index valid requester always wins, and the pointer is neither used nor updated. The pointer register is compiled out.
  - Undefined (default): round-robin as described above.

## Test plan
- Single request: NREQ=4, ALU_LAT=1, req_valid=4'b0010, frame {A=3, B=5, c=0, op=ADD}.
  - req_ready=4'b0010 in cycle 0 and alu_en in cycle 1, with a_in=3, b_in=5.
  - ALU model returns 8; rsp_valid=4'b0010 in cycle 3 with rsp_data=5'b0_1000.
- All four requesting continuously.
  - Grants go 0,1,2,3,0, one every 4 cycles.
  - With ALU_ARB_FIXED_PRIO_EN defined, every grant goes to 0.
- Pointer wrap: last grant to 3, then requesters 1 and 3 valid -> grant 1, then 3.
- Latency: ALU_LAT=3, ALU model delayed 3 cycles.
  - rsp_valid appears in cycle 5 with the correct result.
  - alu_en is high exactly one cycle.
- Reset asserted during WAIT.
  - Outputs drop to 0 immediately; no rsp_valid.
  - After release, a fresh request to 2 is granted, with arbitration starting from pointer 0.
- Invariants checked every cycle: req_ready and rsp_valid are each at most one-hot; no new grant is accepted while an operation is in flight (late request from 0 during EXEC stays waiting).
